reservation_station: RTL and testbench
======================================

# reservation_station

Parametrised reservation station for the out-of-order core, the generalised successor to the fixed per-unit stations (integer, branch/jump, load/store). It holds up to `DEPTH` dispatched µops and snoops `NUM_CDB` common-data-bus channels to capture missing operands. Each cycle it issues the oldest fully-ready entry to its execution unit under a valid/ready handshake. It flushes on misprediction kill and sits between decode/dispatch and one execution unit.

## Interface
Parameters:
- `DEPTH`, 4: entries (≥2).
- `NUM_CDB`, 3: CDB channels snooped.
- `TAG_W`, 6: ROB tag width.
- `DATA_W`, 32: operand width.
- `OP_W`, 16: opaque op payload (opcode, imm, pc bits) carried to execute.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `kill` in 1: flush all entries (mispredict/misload).
- `we` in 1: dispatch request.
- `dc_op` in OP_W: payload.
- `dc_dest` in TAG_W: destination ROB tag.
- `dc_src1`, `dc_src2` in DATA_W+1: bit DATA_W = ready. If ready, bits [DATA_W-1:0] hold the value; else [TAG_W-1:0] hold the producer tag.
- `cdb` in NUM_CDB*(1+TAG_W+DATA_W): channel k = {valid, tag, data}, channel 0 in the LSBs.
- `is_full` out 1: count == DEPTH.
- `count` out $clog2(DEPTH+1): occupied entries.
- `ex_en` out 1: issue valid.
- `ex_ready` in 1: execution unit accepts.
- `ex_op` out OP_W, `ex_dest` out TAG_W, `ex_src1`/`ex_src2` out DATA_W: issued entry contents.

## Operation
- Entry state: valid, op, dest, per-source {ready, tag/data}, and an age-matrix row. `older[i][j]` = entry i dispatched before j.
- **Dispatch:** `we && !is_full && !kill` writes the lowest-index free entry. The age row marks the new entry younger than all valid entries. `we` while full is ignored with no state change and no error.
- **Dispatch-cycle snoop:** a non-ready incoming source whose tag matches a valid CDB channel in the same cycle is stored ready with that channel's data.
- **Wakeup:** every cycle, each non-ready source of each valid entry is compared against all valid CDB channels. On a match it latches the data and sets ready. If several channels match, the lowest channel index wins.
- **Select:** candidate = valid entry with both sources ready. Pick the candidate older than every other candidate. `ex_*` are driven combinationally from that entry's registered contents. `ex_en` = candidate exists && !kill.
- **Issue:** `ex_en && ex_ready` frees the selected entry at the clock edge. With `ex_ready`=0 the selection may change only if an older entry becomes ready. Contents of a held entry never change.
- **Kill:** clears all valid bits at the next edge. It overrides dispatch and issue in the same cycle.
- **Count:** next = count + accepted dispatch − issue, saturating only by construction (never exceeds DEPTH).

## Timing
- Reset (async, `reset`=0): all valid cleared; `ex_en`=0, `count`=0, `is_full`=0 immediately. The `ex_*` data outputs are don't-care while `ex_en`=0.
- Earliest issue: dispatched at edge N (ready operands), `ex_en` high during cycle N+1. No same-cycle dispatch-to-issue.
- CDB wakeup observed in cycle N gives issue eligibility in cycle N+1.
- Dispatch and issue in the same cycle are both permitted.
- `is_full` reflects registered count. A dispatch in a full cycle is rejected even if an issue frees an entry that same cycle.
- Deasserting reset mid-operation: first edge after release behaves as an empty station.

## Test plan
- Reset, then dispatch op=0x0011, dest=3, src1 ready 5, src2 ready 7 → next cycle `ex_en`=1, src1=5, src2=7, dest=3. With `ex_ready`=1, `count` returns to 0 the following cycle.
- Dispatch src1 waiting tag 9. In cycle N, CDB2 = {1,9,0x1234} → `ex_en` rises in N+1 with `ex_src1`=0x1234. A CDB hit on a non-matching tag 8 has no effect.
- Dispatch src2 waiting tag 4 while CDB0 = {1,4,0xAA} in the same cycle → issues next cycle with `ex_src2`=0xAA.
- DEPTH=4: four dispatches → `is_full`=1, `count`=4. A fifth `we` is ignored. Issue plus `we` in the same cycle → dispatch rejected; retry next cycle accepted, `count`=4.
- Dispatch A then B, both waiting tag 1. Wake tag 1 → A issues first, B next. With `ex_ready`=0 for 3 cycles, `ex_*` stays on A unchanged.
- Three entries valid, assert `kill` → `ex_en`=0 that cycle, `count`=0 next. Pull `reset` low mid-issue → `ex_en`=0 and `count`=0 without a clock edge.

Source files
------------

// File: rtl/reservation_station_if.sv
// rtl/reservation_station_if.sv - dispatch, CDB snoop, status and issue bundle for reservation_station
// Ports carried:
//   kill                 flush all entries
//   we, dc_op, dc_dest,
//   dc_src1, dc_src2     dispatch request; src bit DATA_W = ready, else low TAG_W bits = producer tag
//   cdb                  NUM_CDB x {valid, tag, data}, channel 0 in the LSBs
//   is_full, count       occupancy status
//   ex_en, ex_ready,
//   ex_op, ex_dest,
//   ex_src1, ex_src2     issue handshake and selected entry contents
// slave = reservation station side, master = dispatch / execution unit side.
interface reservation_station_if #(
  parameter int DEPTH   = 4,
  parameter int NUM_CDB = 3,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CH_W  = 1 + TAG_W + DATA_W;

  logic                     kill;
  logic                     we;
  logic [OP_W-1:0]          dc_op;
  logic [TAG_W-1:0]         dc_dest;
  logic [DATA_W:0]          dc_src1;
  logic [DATA_W:0]          dc_src2;
  logic [NUM_CDB*CH_W-1:0]  cdb;
  logic                     is_full;
  logic [CNT_W-1:0]         count;
  logic                     ex_en;
  logic                     ex_ready;
  logic [OP_W-1:0]          ex_op;
  logic [TAG_W-1:0]         ex_dest;
  logic [DATA_W-1:0]        ex_src1;
  logic [DATA_W-1:0]        ex_src2;

  modport slave (
    input  kill, we, dc_op, dc_dest, dc_src1, dc_src2, cdb, ex_ready,
    output is_full, count, ex_en, ex_op, ex_dest, ex_src1, ex_src2
  );

  modport master (
    output kill, we, dc_op, dc_dest, dc_src1, dc_src2, cdb, ex_ready,
    input  is_full, count, ex_en, ex_op, ex_dest, ex_src1, ex_src2
  );
endinterface

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - age-ordered reservation station with CDB operand capture
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (0 = reset)
//   rs     reservation_station_if.slave: dispatch, CDB snoop, kill, status, issue handshake
module reservation_station #(
  parameter int DEPTH   = 4,
  parameter int NUM_CDB = 3,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  reservation_station_if.slave  rs
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CH_W  = 1 + TAG_W + DATA_W;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [OP_W-1:0]   op_d    [DEPTH];
  logic [TAG_W-1:0]  dest_q  [DEPTH];
  logic [TAG_W-1:0]  dest_d  [DEPTH];
  logic [DEPTH-1:0]  s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
  // A non-ready source keeps its producer tag in the low TAG_W bits of the value field.
  logic [DATA_W-1:0] s1_val_q [DEPTH];
  logic [DATA_W-1:0] s1_val_d [DEPTH];
  logic [DATA_W-1:0] s2_val_q [DEPTH];
  logic [DATA_W-1:0] s2_val_d [DEPTH];
  // older_q[i][j] = entry i was dispatched before entry j.
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DEPTH-1:0]  cand;
  logic              win;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  free_idx;
  logic              is_full;
  logic              accept;
  logic              issue;

  // Capture from the CDB; iterating high-to-low lets the lowest matching channel win.
  function automatic logic [DATA_W:0] snoop(input logic rdy, input logic [DATA_W-1:0] val,
                                            input logic [NUM_CDB*CH_W-1:0] bus);
    logic [DATA_W:0] res;
    res = {rdy, val};
    if (!rdy) begin
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (bus[k*CH_W+DATA_W+TAG_W] && (bus[k*CH_W+DATA_W +: TAG_W] == val[TAG_W-1:0]))
          res = {1'b1, bus[k*CH_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  // Oldest ready entry: a candidate that is older than every other candidate.
  always_comb begin
    cand      = valid_q & s1_rdy_q & s2_rdy_q;
    win       = 1'b0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      win = cand[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && cand[j] && !older_q[i][j]) win = 1'b0;
      end
      if (win && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  assign is_full = (count_q == CNT_W'(DEPTH));
  // Kill gates both dispatch and issue in the same cycle.
  assign accept  = rs.we && !is_full && !rs.kill;
  assign issue   = rs.ex_en && rs.ex_ready;

  always_comb begin
    valid_d  = valid_q;
    s1_rdy_d = s1_rdy_q;
    s2_rdy_d = s2_rdy_q;
    for (int i = 0; i < DEPTH; i++) begin
      op_d[i]    = op_q[i];
      dest_d[i]  = dest_q[i];
      older_d[i] = older_q[i];
      {s1_rdy_d[i], s1_val_d[i]} = snoop(s1_rdy_q[i], s1_val_q[i], rs.cdb);
      {s2_rdy_d[i], s2_val_d[i]} = snoop(s2_rdy_q[i], s2_val_q[i], rs.cdb);
    end
    if (issue) valid_d[sel_idx] = 1'b0;
    if (accept) begin
      valid_d[free_idx] = 1'b1;
      op_d[free_idx]    = rs.dc_op;
      dest_d[free_idx]  = rs.dc_dest;
      {s1_rdy_d[free_idx], s1_val_d[free_idx]} =
        snoop(rs.dc_src1[DATA_W], rs.dc_src1[DATA_W-1:0], rs.cdb);
      {s2_rdy_d[free_idx], s2_val_d[free_idx]} =
        snoop(rs.dc_src2[DATA_W], rs.dc_src2[DATA_W-1:0], rs.cdb);
      // New entry is younger than every entry currently held.
      older_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != int'(free_idx)) older_d[j][free_idx] = valid_q[j];
      end
    end
    if (rs.kill) valid_d = '0;
    count_d = rs.kill ? '0 : count_q + CNT_W'(accept) - CNT_W'(issue);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]     <= '0;
        dest_q[i]   <= '0;
        s1_val_q[i] <= '0;
        s2_val_q[i] <= '0;
        older_q[i]  <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      s1_rdy_q <= s1_rdy_d;
      s2_rdy_q <= s2_rdy_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]     <= op_d[i];
        dest_q[i]   <= dest_d[i];
        s1_val_q[i] <= s1_val_d[i];
        s2_val_q[i] <= s2_val_d[i];
        older_q[i]  <= older_d[i];
      end
    end
  end

  assign rs.is_full = is_full;
  assign rs.count   = count_q;
  assign rs.ex_en   = sel_found && !rs.kill;
  assign rs.ex_op   = op_q[sel_idx];
  assign rs.ex_dest = dest_q[sel_idx];
  assign rs.ex_src1 = s1_val_q[sel_idx];
  assign rs.ex_src2 = s2_val_q[sel_idx];
endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed self-checking bench for reservation_station
module tb_reservation_station;
  localparam int DEPTH   = 4;
  localparam int NUM_CDB = 3;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 16;
  localparam int CH_W    = 1 + TAG_W + DATA_W;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  reservation_station_if #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W),
                           .DATA_W(DATA_W), .OP_W(OP_W)) rs_if ();

  reservation_station #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W),
                        .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .rs    (rs_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W:0] rdy(input logic [DATA_W-1:0] v);
    return {1'b1, v};
  endfunction

  function automatic logic [DATA_W:0] wt(input logic [TAG_W-1:0] t);
    return {1'b0, {(DATA_W-TAG_W){1'b0}}, t};
  endfunction

  task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dest,
                      input logic [DATA_W:0] s1, input logic [DATA_W:0] s2);
    rs_if.we      = 1'b1;
    rs_if.dc_op   = op;
    rs_if.dc_dest = dest;
    rs_if.dc_src1 = s1;
    rs_if.dc_src2 = s2;
  endtask

  task automatic set_cdb(input int ch, input logic v, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] d);
    rs_if.cdb[ch*CH_W +: CH_W] = {v, t, d};
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    rs_if.kill     = 1'b0;
    rs_if.we       = 1'b0;
    rs_if.dc_op    = '0;
    rs_if.dc_dest  = '0;
    rs_if.dc_src1  = '0;
    rs_if.dc_src2  = '0;
    rs_if.cdb      = '0;
    rs_if.ex_ready = 1'b0;
    #3;
    chk("rst_count", 64'(rs_if.count), 0);
    chk("rst_ex_en", 64'(rs_if.ex_en), 0);
    chk("rst_full", 64'(rs_if.is_full), 0);
    tick();
    reset = 1'b1;
    tick();

    // Ready operands: issue the cycle after dispatch, then drain.
    disp(16'h0011, 6'd3, rdy(32'd5), rdy(32'd7));
    rs_if.ex_ready = 1'b1;
    #1 chk("t1_no_same_cycle", 64'(rs_if.ex_en), 0);
    tick();
    rs_if.we = 1'b0;
    #1;
    chk("t1_ex_en", 64'(rs_if.ex_en), 1);
    chk("t1_src1", 64'(rs_if.ex_src1), 5);
    chk("t1_src2", 64'(rs_if.ex_src2), 7);
    chk("t1_dest", 64'(rs_if.ex_dest), 3);
    chk("t1_op", 64'(rs_if.ex_op), 16'h0011);
    chk("t1_count1", 64'(rs_if.count), 1);
    tick();
    chk("t1_count0", 64'(rs_if.count), 0);
    chk("t1_empty", 64'(rs_if.ex_en), 0);

    // Wakeup through CDB2; a non-matching tag first.
    rs_if.ex_ready = 1'b0;
    disp(16'h0022, 6'd10, wt(6'd9), rdy(32'd1));
    tick();
    rs_if.we = 1'b0;
    set_cdb(0, 1'b1, 6'd8, 32'hDEAD);
    #1 chk("t2_waiting", 64'(rs_if.ex_en), 0);
    tick();
    set_cdb(0, 1'b0, 6'd0, 32'h0);
    #1 chk("t2_tag8_ignored", 64'(rs_if.ex_en), 0);
    set_cdb(2, 1'b1, 6'd9, 32'h1234);
    #1 chk("t2_same_cycle", 64'(rs_if.ex_en), 0);
    tick();
    set_cdb(2, 1'b0, 6'd0, 32'h0);
    #1;
    chk("t2_ex_en", 64'(rs_if.ex_en), 1);
    chk("t2_src1", 64'(rs_if.ex_src1), 32'h1234);
    chk("t2_src2", 64'(rs_if.ex_src2), 1);
    rs_if.ex_ready = 1'b1;
    tick();
    chk("t2_count0", 64'(rs_if.count), 0);

    // Dispatch-cycle snoop; CDB0 and CDB2 both match, lowest channel wins.
    disp(16'h0033, 6'd11, rdy(32'd2), wt(6'd4));
    set_cdb(0, 1'b1, 6'd4, 32'hAA);
    set_cdb(2, 1'b1, 6'd4, 32'hBB);
    tick();
    rs_if.we = 1'b0;
    rs_if.cdb = '0;
    #1;
    chk("t3_ex_en", 64'(rs_if.ex_en), 1);
    chk("t3_src2", 64'(rs_if.ex_src2), 32'hAA);
    chk("t3_src1", 64'(rs_if.ex_src1), 2);
    tick();
    chk("t3_count0", 64'(rs_if.count), 0);

    // Fill to DEPTH, reject while full, age order across reused slot.
    rs_if.ex_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(OP_W'(16'h0040 + i), TAG_W'(i), rdy(DATA_W'(i)), rdy(32'd0));
      tick();
    end
    disp(16'h0099, 6'd9, rdy(32'd9), rdy(32'd9));
    #1;
    chk("t4_full", 64'(rs_if.is_full), 1);
    chk("t4_count4", 64'(rs_if.count), 4);
    chk("t4_oldest", 64'(rs_if.ex_dest), 0);
    tick();
    chk("t4_fifth_ignored", 64'(rs_if.count), 4);
    disp(16'h0055, 6'd5, rdy(32'd5), rdy(32'd5));
    rs_if.ex_ready = 1'b1;
    tick();
    rs_if.ex_ready = 1'b0;
    #1;
    chk("t4_issue_rejects_disp", 64'(rs_if.count), 3);
    chk("t4_not_full", 64'(rs_if.is_full), 0);
    chk("t4_next_oldest", 64'(rs_if.ex_dest), 1);
    tick();
    rs_if.we = 1'b0;
    #1;
    chk("t4_retry_count", 64'(rs_if.count), 4);
    chk("t4_retry_full", 64'(rs_if.is_full), 1);
    chk("t4_retry_op", 64'(rs_if.ex_op), 16'h0041);
    rs_if.ex_ready = 1'b1;
    chk("t4_drain_a", 64'(rs_if.ex_dest), 1);
    tick();
    chk("t4_drain_b", 64'(rs_if.ex_dest), 2);
    tick();
    chk("t4_drain_c", 64'(rs_if.ex_dest), 3);
    tick();
    chk("t4_drain_d", 64'(rs_if.ex_dest), 5);
    tick();
    chk("t4_drained", 64'(rs_if.count), 0);

    // Two entries wait on tag 1; older issues first and holds while stalled.
    rs_if.ex_ready = 1'b0;
    disp(16'h000A, 6'd20, wt(6'd1), rdy(32'd0));
    tick();
    disp(16'h000B, 6'd21, wt(6'd1), rdy(32'd0));
    tick();
    rs_if.we = 1'b0;
    #1 chk("t5_waiting", 64'(rs_if.ex_en), 0);
    set_cdb(1, 1'b1, 6'd1, 32'h77);
    tick();
    rs_if.cdb = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_hold_en", 64'(rs_if.ex_en), 1);
      chk("t5_hold_dest", 64'(rs_if.ex_dest), 20);
      chk("t5_hold_src1", 64'(rs_if.ex_src1), 32'h77);
      tick();
    end
    rs_if.ex_ready = 1'b1;
    tick();
    chk("t5_b_dest", 64'(rs_if.ex_dest), 21);
    chk("t5_b_en", 64'(rs_if.ex_en), 1);
    tick();
    chk("t5_count0", 64'(rs_if.count), 0);
    chk("t5_empty", 64'(rs_if.ex_en), 0);

    // Kill with three valid entries, overriding a same-cycle dispatch.
    rs_if.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(OP_W'(16'h0060 + i), TAG_W'(30 + i), rdy(32'd1), rdy(32'd1));
      tick();
    end
    #1;
    chk("t6_count3", 64'(rs_if.count), 3);
    chk("t6_pre_kill_en", 64'(rs_if.ex_en), 1);
    rs_if.kill = 1'b1;
    #1 chk("t6_kill_en", 64'(rs_if.ex_en), 0);
    tick();
    rs_if.kill = 1'b0;
    rs_if.we   = 1'b0;
    #1;
    chk("t6_kill_count", 64'(rs_if.count), 0);
    chk("t6_kill_empty", 64'(rs_if.ex_en), 0);

    // Asynchronous reset while an issue is pending.
    disp(16'h0070, 6'd40, rdy(32'd3), rdy(32'd4));
    tick();
    rs_if.we = 1'b0;
    rs_if.ex_ready = 1'b1;
    #1 chk("t7_pre_rst_en", 64'(rs_if.ex_en), 1);
    reset = 1'b0;
    #1;
    chk("t7_rst_en", 64'(rs_if.ex_en), 0);
    chk("t7_rst_count", 64'(rs_if.count), 0);
    reset = 1'b1;
    tick();
    chk("t7_after_release", 64'(rs_if.count), 0);
    chk("t7_after_release_en", 64'(rs_if.ex_en), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
